// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, RV32I funct3 values, FSM states and op decode
// for the sequential ALU master.
package alu_ctrl_pkg;

    // ALU drive codes packed as {S, Cin, M}
    localparam logic [5:0] ALU_ZERO = 6'b0000_0_0;
    localparam logic [5:0] ALU_ADD  = 6'b1001_0_1;
    localparam logic [5:0] ALU_SUB  = 6'b0110_1_1;
    localparam logic [5:0] ALU_AND  = 6'b1000_0_0;
    localparam logic [5:0] ALU_OR   = 6'b1110_0_0;
    localparam logic [5:0] ALU_XOR  = 6'b0110_0_0;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC1,
        ST_EXEC2,
        ST_SHIFT,
        ST_RESP
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SLL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND,
        OP_ILL
    } op_e;

    // Bit 30 only means something for SUB (register form) and SRL/SRA.
    function automatic op_e decode_op(
        input logic [2:0] f3,
        input logic       f7b5,
        input logic       imm
    );
        op_e op;
        logic reg_f7;
        op     = OP_ILL;
        reg_f7 = f7b5 && !imm;
        case (f3)
            F3_ADD:  op = reg_f7 ? OP_SUB : OP_ADD;
            F3_SLL:  op = f7b5 ? OP_ILL : OP_SLL;
            F3_SLT:  op = reg_f7 ? OP_ILL : OP_SLT;
            F3_SLTU: op = reg_f7 ? OP_ILL : OP_SLTU;
            F3_XOR:  op = reg_f7 ? OP_ILL : OP_XOR;
            F3_SRL:  op = f7b5 ? OP_SRA : OP_SRL;
            F3_OR:   op = reg_f7 ? OP_ILL : OP_OR;
            F3_AND:  op = reg_f7 ? OP_ILL : OP_AND;
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

    function automatic logic is_shift(input op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Bit-serial shifter: loads operand and count on start, shifts one bit
// per cycle and raises done once the count reaches zero.
module alu_seq_shifter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            left,
    input  logic            arith,
    input  logic [XLEN-1:0] din,
    input  logic [SHW-1:0]  shamt,
    output logic            done,
    output logic [XLEN-1:0] dout
);

    logic [XLEN-1:0] sreg_q, sreg_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            left_q, left_d;
    logic            arith_q, arith_d;
    logic            fill;

    assign fill = arith_q & sreg_q[XLEN-1];

    always_comb begin
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (start) begin
            sreg_d  = din;
            cnt_d   = shamt;
            busy_d  = 1'b1;
            left_d  = left;
            arith_d = arith;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - SHW'(1);
                if (left_q)
                    sreg_d = {sreg_q[XLEN-2:0], 1'b0};
                else
                    sreg_d = {fill, sreg_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    assign done = busy_q && (cnt_q == '0);
    assign dout = sreg_q;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential master for the combinational ALU (RV32I integer ops).
// Optional ALU_SEQ_CTRL_FLAGS_EN adds the rsp_nzcv flag output.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            is_imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] op2_val,
    output logic [XLEN-1:0] alu_opA,
    output logic [XLEN-1:0] alu_opB,
    output logic [3:0]      alu_S,
    output logic            alu_M,
    output logic            alu_Cin,
    input  logic [XLEN-1:0] alu_DO,
    input  logic            alu_C,
    input  logic            alu_V,
    input  logic            alu_N,
    input  logic            alu_Z,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err
`ifdef ALU_SEQ_CTRL_FLAGS_EN
    ,
    output logic [3:0]      rsp_nzcv
`endif
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    op_e             dec_op;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic [5:0]      alu_code;
    logic [XLEN-1:0] opa, opb;
    logic            lt_bit;
    logic            sh_start;
    logic            sh_done;
    logic [XLEN-1:0] sh_dout;

`ifdef ALU_SEQ_CTRL_FLAGS_EN
    logic [3:0] nzcv_q, nzcv_d;
`else
    logic unused_flags;
    assign unused_flags = ^{alu_C, alu_V, alu_N, alu_Z};
`endif

    assign dec_op = decode_op(funct3, funct7b5, is_imm);

    alu_seq_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (sh_start),
        .left  (dec_op == OP_SLL),
        .arith (dec_op == OP_SRA),
        .din   (rs1_val),
        .shamt (op2_val[SHW-1:0]),
        .done  (sh_done),
        .dout  (sh_dout)
    );

    // Mixed signs settle the compare directly; else sign of op2-rs1-1.
    always_comb begin
        if (a_q[XLEN-1] != b_q[XLEN-1])
            lt_bit = (op_q == OP_SLTU) ? b_q[XLEN-1] : a_q[XLEN-1];
        else
            lt_bit = ~alu_DO[XLEN-1];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        data_d   = data_q;
        err_d    = err_q;
        alu_code = ALU_ZERO;
        opa      = '0;
        opb      = '0;
        sh_start = 1'b0;
`ifdef ALU_SEQ_CTRL_FLAGS_EN
        nzcv_d   = nzcv_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d  = dec_op;
                    a_d   = rs1_val;
                    b_d   = op2_val;
                    err_d = (dec_op == OP_ILL);
                    if (is_shift(dec_op)) begin
                        sh_start = 1'b1;
                        state_d  = ST_SHIFT;
                    end else begin
                        state_d = ST_EXEC1;
                    end
                end
            end
            ST_EXEC1: begin
                opa     = a_q;
                opb     = b_q;
                data_d  = alu_DO;
                state_d = ST_RESP;
                case (op_q)
                    OP_ADD: alu_code = ALU_ADD;
                    OP_SUB: begin
                        alu_code = ALU_SUB;
                        state_d  = ST_EXEC2;
                    end
                    OP_XOR: alu_code = ALU_XOR;
                    OP_OR:  alu_code = ALU_OR;
                    OP_AND: alu_code = ALU_AND;
                    OP_SLT, OP_SLTU: begin
                        alu_code = ALU_SUB;
                        opa      = b_q;
                        opb      = a_q;
                        data_d   = {{(XLEN-1){1'b0}}, lt_bit};
                    end
                    default: begin
                        opa    = '0;
                        opb    = '0;
                        data_d = '0;
                    end
                endcase
`ifdef ALU_SEQ_CTRL_FLAGS_EN
                if (op_q == OP_ILL)
                    nzcv_d = 4'b0100;
                else
                    nzcv_d = {alu_N, alu_Z, alu_C, alu_V};
`endif
            end
            ST_EXEC2: begin
                alu_code = ALU_ADD;
                opa      = data_q;
                opb      = XLEN'(1);
                data_d   = alu_DO;
                state_d  = ST_RESP;
`ifdef ALU_SEQ_CTRL_FLAGS_EN
                nzcv_d   = {alu_N, alu_Z, alu_C, alu_V};
`endif
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    data_d  = sh_dout;
                    state_d = ST_RESP;
`ifdef ALU_SEQ_CTRL_FLAGS_EN
                    nzcv_d  = {sh_dout[XLEN-1], sh_dout == '0, 2'b00};
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef ALU_SEQ_CTRL_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nzcv_q <= 4'b0000;
        else
            nzcv_q <= nzcv_d;
    end
    assign rsp_nzcv = nzcv_q;
`endif

    assign {alu_S, alu_Cin, alu_M} = alu_code;
    assign alu_opA   = opa;
    assign alu_opB   = opb;
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural ALU and a
// reference model of the RV32I op results and latencies.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic        is_imm = 1'b0;
    logic [31:0] rs1_val = '0;
    logic [31:0] op2_val = '0;
    logic [31:0] alu_opA, alu_opB;
    logic [3:0]  alu_S;
    logic        alu_M, alu_Cin;
    logic [31:0] alu_DO;
    logic        alu_C, alu_V, alu_N, alu_Z;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
`ifdef ALU_SEQ_CTRL_FLAGS_EN
    logic [3:0]  rsp_nzcv;
`endif

    int errors = 0;
    int checks = 0;
    logic [69:0] alog[$];
    logic [5:0]  code;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .is_imm    (is_imm),
        .rs1_val   (rs1_val),
        .op2_val   (op2_val),
        .alu_opA   (alu_opA),
        .alu_opB   (alu_opB),
        .alu_S     (alu_S),
        .alu_M     (alu_M),
        .alu_Cin   (alu_Cin),
        .alu_DO    (alu_DO),
        .alu_C     (alu_C),
        .alu_V     (alu_V),
        .alu_N     (alu_N),
        .alu_Z     (alu_Z),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
`ifdef ALU_SEQ_CTRL_FLAGS_EN
        ,
        .rsp_nzcv  (rsp_nzcv)
`endif
    );

    // Combinational ALU as seen by the master
    assign code = {alu_S, alu_Cin, alu_M};
    always_comb begin
        alu_DO = '0;
        case (code)
            6'b100101: alu_DO = alu_opA + alu_opB;
            6'b011011: alu_DO = alu_opA - alu_opB - 32'd1;
            6'b100000: alu_DO = alu_opA & alu_opB;
            6'b111000: alu_DO = alu_opA | alu_opB;
            6'b011000: alu_DO = alu_opA ^ alu_opB;
            default:   alu_DO = '0;
        endcase
    end
    assign alu_N = alu_DO[31];
    assign alu_Z = (alu_DO == 32'd0);
    assign alu_C = 1'b0;
    assign alu_V = 1'b0;

    always @(negedge clk) begin
        if (rst_n && (code != 6'd0 || alu_opA != 32'd0 || alu_opB != 32'd0))
            alog.push_back({code, alu_opA, alu_opB});
    end

    task automatic chk(input string tag, input logic [69:0] got,
                       input logic [69:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(
        input  logic [2:0]  f3,
        input  logic        f7,
        input  logic        imm,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] data,
        output logic        err,
        output int          lat
    );
        int sh;
        sh   = int'(b[4:0]);
        data = 32'd0;
        err  = 1'b0;
        lat  = 2;
        if ((f7 && !imm && f3 != 3'd0 && f3 != 3'd5) || (f7 && f3 == 3'd1)) begin
            err = 1'b1;
            return;
        end
        case (f3)
            3'd0: begin
                if (f7 && !imm) begin
                    data = a - b;
                    lat  = 3;
                end else begin
                    data = a + b;
                end
            end
            3'd1: begin
                data = a << sh;
                lat  = sh + 2;
            end
            3'd2: data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: data = (a < b) ? 32'd1 : 32'd0;
            3'd4: data = a ^ b;
            3'd5: begin
                data = f7 ? 32'($signed(a) >>> sh) : (a >> sh);
                lat  = sh + 2;
            end
            3'd6: data = a | b;
            default: data = a & b;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic f7, input logic imm,
                          input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] ed;
        logic        ee;
        int          el;
        int          cyc;
        ref_model(f3, f7, imm, a, b, ed, ee, el);
        chk({tag, ".req_ready"}, 70'(req_ready), 70'd1);
        req_valid = 1'b1;
        funct3    = f3;
        funct7b5  = f7;
        is_imm    = imm;
        rs1_val   = a;
        op2_val   = b;
        rsp_ready = (hold == 0);
        alog.delete();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!rsp_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".latency"}, 70'(cyc), 70'(el));
        chk({tag, ".data"}, 70'(rsp_data), 70'(ed));
        chk({tag, ".err"}, 70'(rsp_err), 70'(ee));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold"}, {rsp_valid, req_ready, rsp_data},
                {1'b1, 1'b0, ed});
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".handshake"}, 70'({rsp_valid, req_ready}), 70'(2'b01));
    endtask

    initial begin
        int seen;
        logic [2:0]  rf3;
        logic        rf7, rimm;
        logic [31:0] ra, rb;

        #2;
        chk("reset.rsp", 70'({rsp_valid, rsp_err, rsp_data}), 70'd0);
        chk("reset.alu", {code, alu_opA, alu_opB}, 70'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.req_ready", 70'(req_ready), 70'd1);

        run_op("add", 3'd0, 1'b0, 1'b0, 32'd5, 32'd7, 0);
        chk("add.alu_n", 70'(alog.size()), 70'd1);
        chk("add.alu_seq", alog[0], {6'b100101, 32'd5, 32'd7});

        run_op("sub", 3'd0, 1'b1, 1'b0, 32'd3, 32'd5, 0);
        chk("sub.alu_n", 70'(alog.size()), 70'd2);
        chk("sub.alu0", alog[0], {6'b011011, 32'd3, 32'd5});
        chk("sub.alu1", alog[1], {6'b100101, 32'hFFFF_FFFD, 32'd1});

        run_op("slt_mix", 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("sltu_mix", 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("slt_eq", 3'd2, 1'b0, 1'b0, 32'd5, 32'd5, 0);
        run_op("slt_lt", 3'd2, 1'b0, 1'b0, 32'd3, 32'd5, 0);
        run_op("sltu_ge", 3'd3, 1'b0, 1'b1, 32'd9, 32'd4, 0);
        run_op("addi_b30", 3'd0, 1'b1, 1'b1, 32'd100, 32'hFFFF_FC00, 0);

        run_op("sra31", 3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'd31, 0);
        run_op("srl4", 3'd5, 1'b0, 1'b0, 32'h8000_00F0, 32'd4, 0);
        run_op("sll0", 3'd1, 1'b0, 1'b1, 32'd1, 32'd0, 0);

        run_op("xor_bp", 3'd4, 1'b0, 1'b0, 32'hA5A5_0F0F, 32'h0FF0_FFFF, 5);
        run_op("and_next", 3'd7, 1'b0, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);

        run_op("or_ill", 3'd6, 1'b1, 1'b0, 32'h1234_5678, 32'd1, 0);
        chk("or_ill.alu_idle", 70'(alog.size()), 70'd0);
        run_op("slli_ill", 3'd1, 1'b1, 1'b1, 32'd3, 32'd2, 0);
        chk("slli_ill.alu_idle", 70'(alog.size()), 70'd0);

        // Reset in the middle of a 20-bit shift
        req_valid = 1'b1;
        funct3    = 3'd5;
        funct7b5  = 1'b0;
        is_imm    = 1'b1;
        rs1_val   = 32'hDEAD_BEEF;
        op2_val   = 32'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.rsp_valid", 70'(rsp_valid), 70'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rsp_valid)
                seen++;
        end
        chk("rst_mid.no_resp", 70'(seen), 70'd0);
        run_op("after_rst", 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);

        for (int n = 0; n < 40; n++) begin
            rf3  = 3'($urandom_range(0, 7));
            rf7  = ($urandom_range(0, 3) == 0);
            rimm = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = $urandom;
            if ($urandom_range(0, 1) == 1)
                rb[31] = ra[31];
            if ($urandom_range(0, 5) == 0)
                rb = ra;
            run_op($sformatf("rnd%0d", n), rf3, rf7, rimm, ra, rb,
                   int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Sequential master for the combinational ALU: accepts RV32I integer ALU operations over a valid/ready request channel and drives the ALU's opA/opB/S/M/Cin inputs.
- Reads back the ALU's DO/C/V/N/Z, sequences multi-pass operations (SUB fix-up, SLT/SLTU) and performs shifts locally, one bit per cycle.
- Returns the result on a valid/ready response channel.
- Sits in the execute stage between decode and writeback.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- SHW, 5, shift-amount width; equals log2(XLEN).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- funct3  in  3  RV32I funct3.
- funct7b5  in  1  instruction bit 30 (SUB/SRA select).
- is_imm  in  1  immediate form; funct7b5 ignored except for shifts.
- rs1_val  in  32  operand A.
- op2_val  in  32  rs2 or sign-extended immediate; shift amount is op2_val[4:0].
- alu_opA, alu_opB  out  32  ALU operands.
- alu_S  out  4  ALU function select.
- alu_M  out  1  ALU arithmetic mode.
- alu_Cin  out  1  ALU carry-in.
- alu_DO  in  32  ALU result.
- alu_C, alu_V, alu_N, alu_Z  in  1  ALU flags.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  32  result.
- rsp_err  out  1  unsupported encoding.

Behaviour:
- Reset (async, rst_n low): state=IDLE; rsp_valid=0, rsp_data=0, rsp_err=0; ALU outputs at idle values; req_ready=1 once rst_n is high.
- Idle ALU drive, used in every state except EXEC1/EXEC2: S=0000, Cin=0, M=0 (set-zero), opA=opB=0.
- ALU codes {S,Cin,M}:
  - ADD = 1001,0,1 → A+B.
  - SUB = 0110,1,1 → A−B−1.
  - AND = 1000,0,0; OR = 1110,0,0; XOR = 0110,0,0.
- req_ready = (state==IDLE). No overlap: a new request is accepted only after the previous response handshake completes.
- FSM states: IDLE, EXEC1, EXEC2, SHIFT, RESP.
  - IDLE: on req_valid&&req_ready, latch the operands and op, then go to EXEC1 (ALU ops) or SHIFT (shift ops).
  - EXEC1: drive the ALU for one cycle and sample alu_DO at the clock edge. SUB goes to EXEC2; all other ops go to RESP.
  - EXEC2 (SUB only): drive ADD with opA=sampled DO, opB=1, giving A−B; then go to RESP.
  - SHIFT: cnt loaded with shamt. If cnt==0, go to RESP; else shift one bit (SLL: <<1 with 0 fill; SRL: >>1 with 0 fill; SRA: >>1 with sign fill) and decrement cnt.
  - RESP: rsp_valid=1, with rsp_data/rsp_err held stable until rsp_ready; then go to IDLE.
- SLT: if rs1[31]≠op2[31], result=rs1[31]; else EXEC1 drives SUB with opA=op2, opB=rs1, and result = ~alu_DO[31]. Result is zero-extended.
- SLTU: if the MSBs differ, result=op2[31]; else the same SUB-based result as SLT.
- Illegal encodings (rsp_err=1, rsp_data=0, latency as a single-pass op, ALU held idle):
  - funct7b5=1 in register form with funct3 not 000 or 101.
  - funct7b5=1 with funct3=001.
- Latency, counted from the accept edge to rsp_valid high:
  - Single-pass ops: 2 cycles.
  - SUB: 3 cycles.
  - Shift by n: n+2 cycles (shift by 0 gives 2).
- Arithmetic wraps modulo 2^32. Carry/overflow are not reported unless the optional feature is compiled in.
- Reset mid-operation discards the op; no response is produced for it.

Optional Feature:
- Macro ALU_SEQ_CTRL_FLAGS_EN.
- Defined:
  - Adds output rsp_nzcv (4 bits, {N,Z,C,V}), captured from the ALU flags on the last ALU pass of the op.
  - For shifts and illegal ops, N and Z are derived from the result and C=V=0.
  - Reset value 0; held stable with rsp_data.
- Undefined: the port is absent and no flag registers are built.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU {S,Cin,M} code constants.
  - RV32I funct3 constants (ADD/SUB=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL/SRA=101, OR=110, AND=111).
  - FSM state enum.
- One sub-module: alu_seq_shifter.
  - Holds the 32-bit shift register, the cnt, and the fill logic.
  - Handshakes: start/done.

Test Plan:
- ADD rs1=5, op2=7 → rsp_data=12, rsp_valid 2 cycles after accept; ALU sees code 1001,0,1 for exactly one cycle.
- SUB rs1=3, op2=5 → rsp_data=0xFFFFFFFE after 3 cycles; ALU sequence is SUB then ADD(0xFFFFFFFD, 1).
- SLT: (0xFFFFFFFF, 1) → 1. SLTU: (0xFFFFFFFF, 1) → 0. SLT (5, 5) → 0. SLT (3, 5) → 1.
- SRA: 0x80000000 by 31 → 0xFFFFFFFF, rsp_valid 33 cycles after accept. SLL 0x1 by 0 → 0x1 at 2 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_data stable and req_ready=0; the next request is accepted the cycle after the handshake.
- Reset and illegal encoding:
  - Assert rst_n=0 mid-SHIFT (shamt=20, cycle 8) → rsp_valid=0 immediately; no response after release.
  - OR with funct7b5=1 in register form → rsp_err=1, rsp_data=0.
